// File: rtl/mu0_mem_arbiter.sv
// Two-requester arbiter for a single-port memory with one-cycle read latency.
// Writes complete in the grant cycle; reads hold the port for a second cycle to return data.
module mu0_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic              proto_err
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [15:0]       cnt0_q, cnt0_d;
    logic [15:0]       cnt1_q, cnt1_d;
    logic              proto_err_q, proto_err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic act0, act1;
    logic granted, pick;
    logic gnt_read, gnt_write;
    logic valid0, valid1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            proto_err_q  <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            proto_err_q  <= proto_err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        proto_err_d  = proto_err_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        granted      = 1'b0;
        pick         = 1'b0;

        act0 = m0_read | m0_write;
        act1 = m1_read | m1_write;

        // No grant while reset is held, so nothing reaches memory during reset.
        if (state_q == IDLE && !rst) begin
            if (act0 && act1) begin
                granted = 1'b1;
                pick    = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
            end else if (act0) begin
                granted = 1'b1;
                pick    = 1'b0;
            end else if (act1) begin
                granted = 1'b1;
                pick    = 1'b1;
            end
        end

        gnt_read  = pick ? m1_read  : m0_read;
        gnt_write = pick ? m1_write : m0_write;

        // Read+write together is illegal: the write wins and the error is latched.
        mem_write     = granted & gnt_write;
        mem_read      = granted & gnt_read & ~gnt_write;
        mem_address   = pick ? m1_address   : m0_address;
        mem_writedata = pick ? m1_writedata : m0_writedata;

        m0_waitrequest = act0 & ~(granted & ~pick);
        m1_waitrequest = act1 & ~(granted &  pick);

        valid0 = (state_q == RD_WAIT) && (owner_q == 1'b0);
        valid1 = (state_q == RD_WAIT) && (owner_q == 1'b1);

        if (granted) begin
            last_grant_d = pick;
            if (gnt_read && gnt_write) begin
                proto_err_d = 1'b1;
            end
            if (mem_read) begin
                state_d = RD_WAIT;
                owner_d = pick;
            end
            if (!pick && cnt0_q != 16'hFFFF) begin
                cnt0_d = cnt0_q + 16'd1;
            end
            if (pick && cnt1_q != 16'hFFFF) begin
                cnt1_d = cnt1_q + 16'd1;
            end
        end

        if (state_q == RD_WAIT) begin
            state_d = IDLE;
            if (valid0) begin
                rdata0_d = mem_readdata;
            end
            if (valid1) begin
                rdata1_d = mem_readdata;
            end
        end
    end

    // Read data passes through in the valid cycle and is held afterwards.
    assign m0_readdatavalid = valid0;
    assign m1_readdatavalid = valid1;
    assign m0_readdata      = valid0 ? mem_readdata : rdata0_q;
    assign m1_readdata      = valid1 ? mem_readdata : rdata1_q;
    assign grant_cnt0       = cnt0_q;
    assign grant_cnt1       = cnt1_q;
    assign proto_err        = proto_err_q;

endmodule
